ethernet_tx_buffer: RTL and testbench
=====================================

// Module: ethernet_tx_buffer
// PURPOSE
//  Frame staging buffer directly upstream of the Ethernet TX MAC. Software/bus side pushes payload
//  bytes, then commits a frame by writing a descriptor (destination MAC, payload length).
//  data_ready_o asserts only when a complete frame is committed, so the MAC streams it without stalls.
//  Contents: a payload byte FIFO plus a descriptor FIFO, both first-word-fall-through (FWFT).
// PARAMETERS
//  PAYLOAD_DEPTH  2048  payload FIFO depth in bytes (power of 2)
//  DESC_DEPTH     8     descriptor FIFO depth in frames (power of 2)
//  MAX_PAYLOAD    1500  largest payload length accepted in a descriptor
// PORTS
//  clk_i               in   1      clock
//  rst_n_i             in   1      reset, asynchronous, active-low
//  flush_i             in   1      synchronous clear of both FIFOs and all counters
//  payload_write_i     in   1      push payload_wdata_i into payload FIFO
//  payload_wdata_i     in   8      payload byte
//  payload_full_o      out  1      payload FIFO full
//  desc_write_i        in   1      commit frame descriptor
//  desc_dest_i         in   [5:0][7:0]  destination MAC, byte 5 = first on wire
//  desc_length_i       in   [1:0][7:0]  payload length, byte 1 = MSB
//  desc_full_o         out  1      descriptor FIFO full
//  desc_reject_o       out  1      1-cycle pulse: descriptor write refused
//  overflow_o          out  1      sticky: payload write while full
//  underflow_o         out  1      sticky: read_data_i or read_descriptor_i while empty
//  data_ready_o        out  1      at least one committed frame
//  read_descriptor_i   in   1      pop head descriptor
//  read_data_i         in   1      pop head payload byte
//  dest_address_o      out  [5:0][7:0]  head descriptor destination (FWFT)
//  payload_length_o    out  [1:0][7:0]  head descriptor length (FWFT)
//  payload_data_o      out  8      head payload byte (FWFT)
//  frames_pending_o    out  $clog2(DESC_DEPTH)+1    committed frames in FIFO
//  uncommitted_o       out  $clog2(PAYLOAD_DEPTH)+1 bytes not yet claimed by a descriptor
// BEHAVIOUR
//  Reset (async) and flush_i (sync, highest priority): pointers, counts, uncommitted_o,
//   overflow_o, underflow_o and desc_reject_o go to 0. data_ready_o=0, payload_full_o=0,
//   desc_full_o=0. Data outputs show head RAM contents; don't-care while empty.
//  Payload FIFO: write accepted iff !payload_full_o. Write when full is dropped and sets
//   overflow_o. Accepted write: uncommitted_o +1.
//  Descriptor accepted iff all hold:
//   !desc_full_o; 1 <= length <= MAX_PAYLOAD; length <= uncommitted_o sampled before this
//   cycle's payload write.
//  On accept: uncommitted_o -= length, at the same time as any +1 from a same-cycle byte write.
//  On refuse: desc_reject_o pulses next cycle; no state changes.
//  Latency: descriptor accepted at edge N -> data_ready_o=1 and dest/length outputs valid after N.
//   Payload write at edge N -> byte visible on payload_data_o after N if FIFO was empty.
//  Pops: read_data_i pops one byte; read_descriptor_i pops one descriptor.
//   Each is ignored when its FIFO is empty and then sets underflow_o.
//   After a pop, the next head is presented the following cycle with no bubble.
//  Simultaneous push+pop on one FIFO, non-empty and non-full: both occur, count unchanged.
//   When full, a pop+push in the same cycle is accepted.
//  data_ready_o = (frames_pending_o != 0). A descriptor pop in the same cycle as a
//   descriptor push leaves frames_pending_o unchanged.
//  Wrap-around: pointers are one bit wider than the address.
//   Full = MSBs differ and address bits equal. Empty = pointers equal.
//   Correct operation across index wrap is required.
//  Consumer contract: the consumer pops exactly payload_length_o bytes per descriptor.
//   The buffer does not police this.
//  Descriptor RAM word is 64 bits: {dest, length}. Payload RAM is 8-bit, inferable as block RAM.
// TESTING
//  1. Write 64 bytes 0x00..0x3F, then descriptor (dest 02:00:00:00:00:01, len 64) -> data_ready_o=1
//     next cycle, uncommitted_o=0; 64 read_data_i pops return 0x00..0x3F in order.
//  2. Write 10 bytes, then descriptor len 11 -> desc_reject_o pulses, frames_pending_o=0,
//     uncommitted_o=10.
//  3. Descriptor len 0 and len 1501 -> both rejected. Len 1500 with 1500 bytes buffered -> accepted.
//  4. Fill PAYLOAD_DEPTH bytes -> payload_full_o=1; extra write -> overflow_o=1, data unchanged.
//     Pop+push same cycle -> accepted.
//  5. Commit 8 frames -> desc_full_o; 9th refused. Pop all across several wrap cycles -> data and
//     order intact.
//  6. flush_i and async reset mid-frame (after 5 bytes popped) -> all counts 0, data_ready_o=0,
//     sticky flags cleared; a new frame then works normally.

Source files
------------

// File: rtl/ethernet_tx_buffer_if.sv
// Bus bundle for the Ethernet TX staging buffer: software push side, descriptor commit and MAC pop side.
// The master modport is the bus/MAC side; the slave modport is the buffer itself.
interface ethernet_tx_buffer_if #(
    parameter int PAYLOAD_DEPTH = 2048,
    parameter int DESC_DEPTH    = 8
);
    localparam int PAW = $clog2(PAYLOAD_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);

    logic                flush_i;
    logic                payload_write_i;
    logic [7:0]          payload_wdata_i;
    logic                payload_full_o;
    logic                desc_write_i;
    logic [5:0][7:0]     desc_dest_i;
    logic [1:0][7:0]     desc_length_i;
    logic                desc_full_o;
    logic                desc_reject_o;
    logic                overflow_o;
    logic                underflow_o;
    logic                data_ready_o;
    logic                read_descriptor_i;
    logic                read_data_i;
    logic [5:0][7:0]     dest_address_o;
    logic [1:0][7:0]     payload_length_o;
    logic [7:0]          payload_data_o;
    logic [DAW:0]        frames_pending_o;
    logic [PAW:0]        uncommitted_o;

    modport master (
        output flush_i, payload_write_i, payload_wdata_i, desc_write_i, desc_dest_i,
               desc_length_i, read_descriptor_i, read_data_i,
        input  payload_full_o, desc_full_o, desc_reject_o, overflow_o, underflow_o,
               data_ready_o, dest_address_o, payload_length_o, payload_data_o,
               frames_pending_o, uncommitted_o
    );

    modport slave (
        input  flush_i, payload_write_i, payload_wdata_i, desc_write_i, desc_dest_i,
               desc_length_i, read_descriptor_i, read_data_i,
        output payload_full_o, desc_full_o, desc_reject_o, overflow_o, underflow_o,
               data_ready_o, dest_address_o, payload_length_o, payload_data_o,
               frames_pending_o, uncommitted_o
    );
endinterface

// File: rtl/ethernet_tx_buffer.sv
// Frame staging buffer ahead of the Ethernet TX MAC: FWFT payload byte FIFO plus FWFT descriptor FIFO.
// A frame only becomes visible to the MAC once its descriptor is committed, so streaming never stalls.
module ethernet_tx_buffer #(
    parameter int PAYLOAD_DEPTH = 2048,
    parameter int DESC_DEPTH    = 8,
    parameter int MAX_PAYLOAD   = 1500
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    ethernet_tx_buffer_if.slave  bus
);
    localparam int PAW = $clog2(PAYLOAD_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef logic [PAW:0] payPtr_t;
    typedef logic [DAW:0] descPtr_t;

    logic [7:0]  payRam  [PAYLOAD_DEPTH];
    logic [63:0] descRam [DESC_DEPTH];

    payPtr_t  payWrPtr_q, payWrPtr_d, payRdPtr_q, payRdPtr_d;
    payPtr_t  uncommitted_q, uncommitted_d;
    descPtr_t descWrPtr_q, descWrPtr_d, descRdPtr_q, descRdPtr_d;
    logic     overflow_q, overflow_d, underflow_q, underflow_d, descReject_q, descReject_d;
    logic [7:0]  payHead_q;
    logic [63:0] descHead_q;

    logic        payEmpty, payFull, descEmpty, descFull;
    logic        payPush, payPop, descPush, descPop, lenOk;
    logic [15:0] descLen;

    assign descLen = bus.desc_length_i;

    // Length is checked against the uncommitted count from before this cycle's byte write.
    always_comb begin
        payEmpty  = (payWrPtr_q == payRdPtr_q);
        payFull   = (payWrPtr_q[PAW] != payRdPtr_q[PAW]) &&
                    (payWrPtr_q[PAW-1:0] == payRdPtr_q[PAW-1:0]);
        descEmpty = (descWrPtr_q == descRdPtr_q);
        descFull  = (descWrPtr_q[DAW] != descRdPtr_q[DAW]) &&
                    (descWrPtr_q[DAW-1:0] == descRdPtr_q[DAW-1:0]);
        lenOk     = (descLen != 16'd0) && (descLen <= MAX_LEN) &&
                    (32'(descLen) <= 32'(uncommitted_q));

        payPop   = !bus.flush_i && bus.read_data_i && !payEmpty;
        payPush  = !bus.flush_i && bus.payload_write_i && (!payFull || payPop);
        descPop  = !bus.flush_i && bus.read_descriptor_i && !descEmpty;
        descPush = !bus.flush_i && bus.desc_write_i && lenOk && (!descFull || descPop);

        payWrPtr_d    = payWrPtr_q + payPtr_t'(payPush);
        payRdPtr_d    = payRdPtr_q + payPtr_t'(payPop);
        descWrPtr_d   = descWrPtr_q + descPtr_t'(descPush);
        descRdPtr_d   = descRdPtr_q + descPtr_t'(descPop);
        uncommitted_d = uncommitted_q + payPtr_t'(payPush) - (descPush ? payPtr_t'(descLen) : '0);
        overflow_d    = overflow_q | (bus.payload_write_i && !payPush);
        underflow_d   = underflow_q | (bus.read_data_i && payEmpty) |
                        (bus.read_descriptor_i && descEmpty);
        descReject_d  = bus.desc_write_i && !descPush;

        if (bus.flush_i) begin
            payWrPtr_d    = '0;
            payRdPtr_d    = '0;
            descWrPtr_d   = '0;
            descRdPtr_d   = '0;
            uncommitted_d = '0;
            overflow_d    = 1'b0;
            underflow_d   = 1'b0;
            descReject_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            payWrPtr_q    <= '0;
            payRdPtr_q    <= '0;
            descWrPtr_q   <= '0;
            descRdPtr_q   <= '0;
            uncommitted_q <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            descReject_q  <= 1'b0;
        end else begin
            payWrPtr_q    <= payWrPtr_d;
            payRdPtr_q    <= payRdPtr_d;
            descWrPtr_q   <= descWrPtr_d;
            descRdPtr_q   <= descRdPtr_d;
            uncommitted_q <= uncommitted_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            descReject_q  <= descReject_d;
        end
    end

    // Registered read at the next head address; a write into that slot is forwarded so an
    // empty FIFO shows the new word right after the write edge.
    always_ff @(posedge clk_i) begin
        if (payPush) begin
            payRam[payWrPtr_q[PAW-1:0]] <= bus.payload_wdata_i;
        end
        if (payPush && (payWrPtr_q[PAW-1:0] == payRdPtr_d[PAW-1:0])) begin
            payHead_q <= bus.payload_wdata_i;
        end else begin
            payHead_q <= payRam[payRdPtr_d[PAW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (descPush) begin
            descRam[descWrPtr_q[DAW-1:0]] <= {bus.desc_dest_i, bus.desc_length_i};
        end
        if (descPush && (descWrPtr_q[DAW-1:0] == descRdPtr_d[DAW-1:0])) begin
            descHead_q <= {bus.desc_dest_i, bus.desc_length_i};
        end else begin
            descHead_q <= descRam[descRdPtr_d[DAW-1:0]];
        end
    end

    assign bus.payload_full_o   = payFull;
    assign bus.desc_full_o      = descFull;
    assign bus.desc_reject_o    = descReject_q;
    assign bus.overflow_o       = overflow_q;
    assign bus.underflow_o      = underflow_q;
    assign bus.frames_pending_o = descWrPtr_q - descRdPtr_q;
    assign bus.data_ready_o     = (descWrPtr_q != descRdPtr_q);
    assign bus.uncommitted_o    = uncommitted_q;
    assign bus.payload_data_o   = payHead_q;
    assign bus.dest_address_o   = descHead_q[63:16];
    assign bus.payload_length_o = descHead_q[15:0];
endmodule

// File: tb/tb_ethernet_tx_buffer.sv
// Scoreboard bench for ethernet_tx_buffer: queues hold expected bytes and descriptors,
// heads are compared as the consumer pops them, and status is compared after every cycle.
module tb_ethernet_tx_buffer;
    localparam int PDEPTH = 2048;
    localparam int DDEPTH = 8;
    localparam int MAXP   = 1500;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    ethernet_tx_buffer_if #(.PAYLOAD_DEPTH(PDEPTH), .DESC_DEPTH(DDEPTH)) bus();

    ethernet_tx_buffer #(.PAYLOAD_DEPTH(PDEPTH), .DESC_DEPTH(DDEPTH), .MAX_PAYLOAD(MAXP)) dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (bus)
    );

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  byteQ[$];
    logic [63:0] descQ[$];
    int uncommittedM;
    bit overflowM, underflowM, rejectM;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearModel();
        byteQ.delete();
        descQ.delete();
        uncommittedM = 0;
        overflowM = 0;
        underflowM = 0;
        rejectM = 0;
    endtask

    task automatic checkStatus();
        checkOutput("frames_pending", 64'(bus.frames_pending_o), 64'(descQ.size()));
        checkOutput("data_ready", 64'(bus.data_ready_o), 64'(descQ.size() != 0));
        checkOutput("uncommitted", 64'(bus.uncommitted_o), 64'(uncommittedM));
        checkOutput("payload_full", 64'(bus.payload_full_o), 64'(byteQ.size() == PDEPTH));
        checkOutput("desc_full", 64'(bus.desc_full_o), 64'(descQ.size() == DDEPTH));
        checkOutput("overflow", 64'(bus.overflow_o), 64'(overflowM));
        checkOutput("underflow", 64'(bus.underflow_o), 64'(underflowM));
        checkOutput("desc_reject", 64'(bus.desc_reject_o), 64'(rejectM));
    endtask

    // One clock of stimulus; expectations are pushed/popped from the scoreboard around the edge.
    task automatic applyStimulus(input bit wr, input logic [7:0] wdata, input bit dw,
                                 input logic [47:0] dest, input logic [15:0] len,
                                 input bit rd, input bit rdd);
        bit popB, popD, pushB, pushD;
        @(negedge clk);
        popB = rd && (byteQ.size() > 0);
        popD = rdd && (descQ.size() > 0);
        if (popB) checkOutput("payload_head", 64'(bus.payload_data_o), 64'(byteQ[0]));
        if (popD) checkOutput("desc_head", 64'({bus.dest_address_o, bus.payload_length_o}), descQ[0]);
        pushB = wr && ((byteQ.size() < PDEPTH) || popB);
        pushD = dw && ((descQ.size() < DDEPTH) || popD) && (len >= 16'd1) &&
                (int'(len) <= MAXP) && (int'(len) <= uncommittedM);
        bus.payload_write_i   = wr;
        bus.payload_wdata_i   = wdata;
        bus.desc_write_i      = dw;
        bus.desc_dest_i       = dest;
        bus.desc_length_i     = len;
        bus.read_data_i       = rd;
        bus.read_descriptor_i = rdd;
        @(posedge clk);
        #1;
        bus.payload_write_i   = 1'b0;
        bus.desc_write_i      = 1'b0;
        bus.read_data_i       = 1'b0;
        bus.read_descriptor_i = 1'b0;
        if (popB) void'(byteQ.pop_front());
        if (popD) void'(descQ.pop_front());
        if (pushB) byteQ.push_back(wdata);
        if (pushD) descQ.push_back({dest, len});
        uncommittedM = uncommittedM + int'(pushB) - (pushD ? int'(len) : 0);
        overflowM  = overflowM | (wr && !pushB);
        underflowM = underflowM | (rd && !popB) | (rdd && !popD);
        rejectM    = dw && !pushD;
        checkStatus();
    endtask

    task automatic writeByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic writeDesc(input logic [47:0] dest, input logic [15:0] len);
        applyStimulus(1'b0, '0, 1'b1, dest, len, 1'b0, 1'b0);
    endtask

    task automatic popByte();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic popDesc();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic drainFrame();
        int n;
        n = (descQ.size() > 0) ? int'(descQ[0][15:0]) : 0;
        popDesc();
        for (int i = 0; i < n; i++) popByte();
    endtask

    task automatic doFlush();
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        clearModel();
        checkStatus();
    endtask

    task automatic doAsyncReset();
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        clearModel();
        checkStatus();
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkStatus();
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.payload_write_i = 1'b0;
        bus.payload_wdata_i = '0;
        bus.desc_write_i = 1'b0;
        bus.desc_dest_i = '0;
        bus.desc_length_i = '0;
        bus.read_data_i = 1'b0;
        bus.read_descriptor_i = 1'b0;
        rstN = 1'b0;
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        checkStatus();
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] basic 64-byte frame");
        for (int i = 0; i < 64; i++) writeByte(8'(i));
        writeDesc(48'h02_00_00_00_00_01, 16'd64);
        checkOutput("t1_ready", 64'(bus.data_ready_o), 64'd1);
        checkOutput("t1_uncommitted", 64'(bus.uncommitted_o), 64'd0);
        checkOutput("t1_dest", 64'(bus.dest_address_o), 64'h02_00_00_00_00_01);
        checkOutput("t1_len", 64'(bus.payload_length_o), 64'd64);
        checkOutput("t1_first_byte", 64'(bus.payload_data_o), 64'h00);
        drainFrame();

        $display("[TB] descriptor longer than buffered payload");
        for (int i = 0; i < 10; i++) writeByte(8'(8'hA0 + i));
        writeDesc(48'h11_22_33_44_55_66, 16'd11);
        checkOutput("t2_reject", 64'(bus.desc_reject_o), 64'd1);
        checkOutput("t2_frames", 64'(bus.frames_pending_o), 64'd0);
        checkOutput("t2_uncommitted", 64'(bus.uncommitted_o), 64'd10);

        $display("[TB] length limits");
        writeDesc(48'h11_22_33_44_55_66, 16'd0);
        checkOutput("t3_reject_len0", 64'(bus.desc_reject_o), 64'd1);
        writeDesc(48'h11_22_33_44_55_66, 16'd1501);
        checkOutput("t3_reject_len1501", 64'(bus.desc_reject_o), 64'd1);
        for (int i = 0; i < 1490; i++) writeByte(8'(i * 3));
        writeDesc(48'hAA_BB_CC_DD_EE_FF, 16'd1500);
        checkOutput("t3_accept_1500", 64'(bus.desc_reject_o), 64'd0);
        checkOutput("t3_ready", 64'(bus.data_ready_o), 64'd1);
        drainFrame();

        $display("[TB] payload full, overflow, push+pop at full");
        for (int i = 0; i < PDEPTH; i++) writeByte(8'(i * 7 + 3));
        checkOutput("t4_full", 64'(bus.payload_full_o), 64'd1);
        writeByte(8'hEE);
        checkOutput("t4_overflow", 64'(bus.overflow_o), 64'd1);
        checkOutput("t4_head_kept", 64'(bus.payload_data_o), 64'h03);
        applyStimulus(1'b1, 8'h5A, 1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("t4_full_after_pushpop", 64'(bus.payload_full_o), 64'd1);
        checkOutput("t4_uncommitted", 64'(bus.uncommitted_o), 64'(PDEPTH + 1));
        while (byteQ.size() > 0) popByte();
        doFlush();
        checkOutput("t4_flush_overflow", 64'(bus.overflow_o), 64'd0);

        $display("[TB] descriptor full and wrap");
        for (int f = 0; f < DDEPTH; f++) begin
            for (int b = 0; b < f + 3; b++) writeByte(8'(f * 16 + b));
            writeDesc({40'h0A_0B_0C_0D_0E, 8'(f)}, 16'(f + 3));
        end
        checkOutput("t5_desc_full", 64'(bus.desc_full_o), 64'd1);
        writeByte(8'hC1);
        writeByte(8'hC2);
        writeDesc(48'h0A_0B_0C_0D_0E_FF, 16'd2);
        checkOutput("t5_reject_9th", 64'(bus.desc_reject_o), 64'd1);
        for (int f = 0; f < DDEPTH; f++) drainFrame();
        popByte();
        popByte();
        for (int r = 0; r < 3; r++) begin
            for (int f = 0; f < 5; f++) begin
                for (int b = 0; b < r + f + 1; b++) writeByte(8'($urandom_range(0, 255)));
                writeDesc({32'hB0B0_0000, 8'(r), 8'(f)}, 16'(r + f + 1));
            end
            for (int f = 0; f < 5; f++) drainFrame();
        end

        $display("[TB] flush and async reset mid-frame");
        for (int i = 0; i < 10; i++) writeByte(8'(8'h40 + i));
        writeDesc(48'h02_00_00_00_00_02, 16'd10);
        popDesc();
        for (int i = 0; i < 5; i++) popByte();
        popDesc();
        checkOutput("t6_underflow", 64'(bus.underflow_o), 64'd1);
        doFlush();
        checkOutput("t6_flush_ready", 64'(bus.data_ready_o), 64'd0);
        checkOutput("t6_flush_underflow", 64'(bus.underflow_o), 64'd0);
        for (int i = 0; i < 4; i++) writeByte(8'(8'h90 + i));
        writeDesc(48'h02_00_00_00_00_03, 16'd4);
        drainFrame();
        for (int i = 0; i < 10; i++) writeByte(8'(8'h60 + i));
        writeDesc(48'h02_00_00_00_00_04, 16'd10);
        popDesc();
        for (int i = 0; i < 5; i++) popByte();
        doAsyncReset();
        checkOutput("t6_reset_uncommitted", 64'(bus.uncommitted_o), 64'd0);
        for (int i = 0; i < 6; i++) writeByte(8'(8'h70 + i));
        writeDesc(48'h02_00_00_00_00_05, 16'd6);
        checkOutput("t6_new_frame_ready", 64'(bus.data_ready_o), 64'd1);
        drainFrame();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
